// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and frame/oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int UART_OVERSAMPLE   = 16;
    localparam int UART_SAMPLE_POINT = 7;
    localparam int UART_DATA_BITS    = 8;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud * (UART_OVERSAMPLE / 2)) / (baud * UART_OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: divides the clock by DIV, restartable so a bit
// period can be aligned to the detected start edge. Shared with the transmitter.
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clock,
    input  logic reset_in,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(DIV - 1));

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in)
            cnt <= '0;
        else if (restart || wrap)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = wrap && !restart;

endmodule

// File: rtl/uart_rx_unit.sv
// 16x-oversampled UART receiver with one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8-E-1 frames; otherwise 8-N-1 and parity_err is 0.
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200,
    parameter int unsigned DIV    = baud_div(CLK_HZ, BAUD)
) (
    input  logic       clock,
    input  logic       reset_in,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    logic       rx_meta, rx_s;
    logic       tick, restart, sample;
    rx_state_t  state, state_nxt;
    logic [3:0] os, os_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       deliver, fe;
`ifdef UART_RX_PARITY_EN
    logic       par_bad, par_bad_nxt;
`endif

    // Both flops reset high so reset never looks like a start edge.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clock    (clock),
        .reset_in (reset_in),
        .restart  (restart),
        .tick     (tick)
    );

    assign sample = tick && (os == 4'(UART_SAMPLE_POINT));

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            state   <= ST_IDLE;
            os      <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            os      <= os_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_nxt;
`endif
        end
    end

    // os free-runs after the start edge, so every centre falls 16 ticks apart.
    always_comb begin
        state_nxt   = state;
        os_nxt      = tick ? os + 4'd1 : os;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        restart     = 1'b0;
        deliver     = 1'b0;
        fe          = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
`endif
        case (state)
            ST_IDLE: begin
                os_nxt = '0;
                if (!rx_s) begin
                    state_nxt = ST_START;
                    restart   = 1'b1;
`ifdef UART_RX_PARITY_EN
                    par_bad_nxt = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (sample) begin
                    state_nxt   = rx_s ? ST_IDLE : ST_DATA;
                    bit_idx_nxt = '0;
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shreg_nxt = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'(UART_DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    else
                        bit_idx_nxt = bit_idx + 3'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample) begin
                    par_bad_nxt = rx_s ^ (^shreg);
                    state_nxt   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (sample) begin
                    if (rx_s) begin
                        deliver   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        fe        = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // A consumer taking the old byte in the delivery cycle frees the slot.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= fe;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in)
            parity_err <= 1'b0;
        else
            parity_err <= deliver && (!rx_valid || rx_ready) && par_bad;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed self-checking bench for uart_rx_unit at 16 clocks per bit.
module tb_uart_rx_unit;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Negedge (counted from the start-bit drive) that precedes the stop-centre sample edge.
    localparam int DELIVER_NEG = 8 + (FRAME_BITS - 1) * BIT_CLKS + 2;

    logic       clock = 1'b0;
    logic       reset_in = 1'b0;
    logic       UART_RX = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err, busy;

    int errors = 0;
    int checks = 0;

    int valid_cyc = 0, fe_cnt = 0, ovr_cnt = 0, par_cnt = 0, busy_cyc = 0;
    logic [7:0] last_data = 8'h00;

    uart_rx_unit #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clock      (clock),
        .reset_in   (reset_in),
        .UART_RX    (UART_RX),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #2;
        if (rx_valid) begin
            valid_cyc = valid_cyc + 1;
            last_data = rx_data;
        end
        if (frame_err)  fe_cnt   = fe_cnt + 1;
        if (overrun)    ovr_cnt  = ovr_cnt + 1;
        if (parity_err) par_cnt  = par_cnt + 1;
        if (busy)       busy_cyc = busy_cyc + 1;
    end

    // Called at a negedge; leaves the line at stop_bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        UART_RX = 1'b0;
        repeat (BIT_CLKS) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            repeat (BIT_CLKS) @(negedge clock);
        end
`ifdef UART_RX_PARITY_EN
        UART_RX = (^d) ^ bad_par;
        repeat (BIT_CLKS) @(negedge clock);
`else
        if (bad_par) UART_RX = 1'b1;
`endif
        UART_RX = stop_bit;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
        reset_in = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_basic();
        int v0, f0, o0, p0;
        v0 = valid_cyc; f0 = fe_cnt; o0 = ovr_cnt; p0 = par_cnt;
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clock);
        checks++; if (valid_cyc - v0 !== 1) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_cyc - v0); end
        checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", last_data); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL basic_frame_err got=%0d exp=0", fe_cnt - f0); end
        checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL basic_overrun got=%0d exp=0", ovr_cnt - o0); end
        checks++; if (par_cnt - p0 !== 0) begin errors++; $display("FAIL basic_parity_err got=%0d exp=0", par_cnt - p0); end
    endtask

    task automatic test_glitch();
        int v0, f0, b0;
        v0 = valid_cyc; f0 = fe_cnt; b0 = busy_cyc;
        UART_RX = 1'b0;
        repeat (BIT_CLKS / 4) @(negedge clock);
        UART_RX = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock);
        checks++; if (busy_cyc - b0 <= 0) begin errors++; $display("FAIL glitch_start_seen got=%0d exp>0", busy_cyc - b0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b exp=0", busy); end
        checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL glitch_valid got=%0d exp=0", valid_cyc - v0); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - f0); end
    endtask

    task automatic test_frame_error();
        int v0, f0;
        v0 = valid_cyc; f0 = fe_cnt;
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (3 * BIT_CLKS) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got=%b exp=1", busy); end
        UART_RX = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_exit_busy got=%b exp=0", busy); end
        checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL frame_err_pulses got=%0d exp=1", fe_cnt - f0); end
        checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL frame_err_valid got=%0d exp=0", valid_cyc - v0); end
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clock);
        checks++; if (valid_cyc - v0 !== 1) begin errors++; $display("FAIL after_break_valid got=%0d exp=1", valid_cyc - v0); end
        checks++; if (last_data !== 8'h81) begin errors++; $display("FAIL after_break_data got=%h exp=81", last_data); end
        checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL after_break_frame_err got=%0d exp=1", fe_cnt - f0); end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ovr_cnt;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        repeat (BIT_CLKS) @(negedge clock);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (BIT_CLKS) @(negedge clock);
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL overrun_pulses got=%0d exp=1", ovr_cnt - o0); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid got=%b exp=1", rx_valid); end
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL overrun_data_kept got=%h exp=11", rx_data); end
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL consume_valid_drop got=%b exp=0", rx_valid); end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int o0;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        repeat (BIT_CLKS) @(negedge clock);
        o0 = ovr_cnt;
        fork
            send_frame(8'h22, 1'b1, 1'b0);
            begin
                repeat (DELIVER_NEG) @(negedge clock);
                checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL b2b_held_data got=%h exp=11", rx_data); end
                rx_ready = 1'b1;
                @(negedge clock);
                rx_ready = 1'b0;
                checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_stays got=%b exp=1", rx_valid); end
                checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL b2b_new_data got=%h exp=22", rx_data); end
            end
        join
        repeat (BIT_CLKS) @(negedge clock);
        checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL b2b_overrun got=%0d exp=0", ovr_cnt - o0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0, p0;
        v0 = valid_cyc; p0 = par_cnt;
        rx_ready = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (2 * BIT_CLKS) @(negedge clock);
        checks++; if (valid_cyc - v0 !== 1) begin errors++; $display("FAIL parity_valid got=%0d exp=1", valid_cyc - v0); end
        checks++; if (last_data !== 8'h07) begin errors++; $display("FAIL parity_data got=%h exp=07", last_data); end
        checks++; if (par_cnt - p0 !== 1) begin errors++; $display("FAIL parity_err_pulses got=%0d exp=1", par_cnt - p0); end
        rx_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_frame();
        int v0, f0;
        rx_ready = 1'b0;
        send_frame(8'h6E, 1'b1, 1'b0);
        repeat (BIT_CLKS) @(negedge clock);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", rx_valid); end
        UART_RX = 1'b0;
        repeat (BIT_CLKS) @(negedge clock);
        UART_RX = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_frame_busy got=%b exp=1", busy); end
        reset_in = 1'b0;
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data got=%h exp=00", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        repeat (4) @(negedge clock);
        reset_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock);
        v0 = valid_cyc; f0 = fe_cnt;
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clock);
        checks++; if (valid_cyc - v0 !== 1) begin errors++; $display("FAIL post_reset_valid got=%0d exp=1", valid_cyc - v0); end
        checks++; if (last_data !== 8'h5A) begin errors++; $display("FAIL post_reset_data got=%h exp=5a", last_data); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL post_reset_frame_err got=%0d exp=0", fe_cnt - f0); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
